// File: rtl/m_mem_access_pkg.sv
// rtl/m_mem_access_pkg.sv - MEMop encodings, exception codes and FSM states for the M-stage LSU
package m_mem_access_pkg;

  localparam logic [2:0] MEMOP_LW  = 3'd0;
  localparam logic [2:0] MEMOP_LH  = 3'd1;
  localparam logic [2:0] MEMOP_LHU = 3'd2;
  localparam logic [2:0] MEMOP_LB  = 3'd3;
  localparam logic [2:0] MEMOP_LBU = 3'd4;
  localparam logic [2:0] MEMOP_SW  = 3'd5;
  localparam logic [2:0] MEMOP_SH  = 3'd6;
  localparam logic [2:0] MEMOP_SB  = 3'd7;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic logic is_store(input logic [2:0] op);
    return (op == MEMOP_SW) || (op == MEMOP_SH) || (op == MEMOP_SB);
  endfunction

endpackage

// File: rtl/m_load_ext.sv
// rtl/m_load_ext.sv - selects the addressed lane of a bus word and sign/zero-extends it
module m_load_ext
  import m_mem_access_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = bus_rdata[8*addr +: 8];
    half_sel = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (mem_op)
      MEMOP_LB:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_LBU: ext_data = {24'h0, byte_sel};
      MEMOP_LH:  ext_data = {{16{half_sel[15]}}, half_sel};
      MEMOP_LHU: ext_data = {16'h0, half_sel};
      default:   ext_data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/m_mem_access.sv
// rtl/m_mem_access.sv - memory-stage load/store unit with address checks and bus req/ack handshake
module m_mem_access
  import m_mem_access_pkg::*;
#(
  parameter logic [31:0] DM_TOP  = 32'h0000_2FFF,
  parameter logic [31:0] T0_BASE = 32'h0000_7F00,
  parameter logic [31:0] T1_BASE = 32'h0000_7F10,
  parameter logic [31:0] IG_BASE = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic        addr_ovf,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_e      state;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] ext_data;

  logic        st, word_op, half_op, misalign;
  logic        in_dm, in_t0, in_t1, in_ig, in_timer, cnt_reg, exc;
  logic [3:0]  be_n;
  logic [31:0] wd_n;

  m_load_ext u_load_ext (
    .mem_op    (op_q),
    .addr      (lane_q),
    .bus_rdata (bus_rdata),
    .ext_data  (ext_data)
  );

  always_comb begin
    st       = is_store(mem_op);
    word_op  = (mem_op == MEMOP_LW) || (mem_op == MEMOP_SW);
    half_op  = (mem_op == MEMOP_LH) || (mem_op == MEMOP_LHU) || (mem_op == MEMOP_SH);
    misalign = (word_op && (addr[1:0] != 2'b00)) || (half_op && addr[0]);
    in_dm    = (addr <= DM_TOP);
    in_t0    = (addr >= T0_BASE) && (addr <= T0_BASE + 32'd11);
    in_t1    = (addr >= T1_BASE) && (addr <= T1_BASE + 32'd11);
    in_ig    = (addr >= IG_BASE) && (addr <= IG_BASE + 32'd3);
    in_timer = in_t0 || in_t1;
    // COUNT is read-only; only aligned word stores reach this term unflagged
    cnt_reg  = (addr == T0_BASE + 32'd8) || (addr == T1_BASE + 32'd8);
    exc      = misalign || addr_ovf || !(in_dm || in_timer || in_ig) ||
               (in_timer && !word_op) || (in_timer && st && cnt_reg);

    be_n = 4'b1111;
    wd_n = 32'h0;
    case (mem_op)
      MEMOP_SW: wd_n = wdata;
      MEMOP_SH: begin
        be_n = addr[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{wdata[15:0]}};
      end
      MEMOP_SB: begin
        be_n = 4'b0001 << addr[1:0];
        wd_n = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign stall = req_valid & ~done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_q      <= 3'd0;
      lane_q    <= 2'd0;
      done      <= 1'b0;
      rdata     <= 32'h0;
      exc_valid <= 1'b0;
      exc_code  <= 5'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'b0;
      bus_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && !flush) begin
            op_q   <= mem_op;
            lane_q <= addr[1:0];
            if (exc) begin
              exc_valid <= 1'b1;
              exc_code  <= st ? EXC_ADES : EXC_ADEL;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= st;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be_n;
              bus_wdata <= wd_n;
              state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // flush wins over ack: the cancelled access must not signal done
          if (flush) begin
            if (bus_ack) begin
              bus_req <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              state <= ST_DRAIN;
            end
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            rdata   <= ext_data;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          exc_valid <= 1'b0;
          exc_code  <= 5'd0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_access.sv
// tb/tb_m_mem_access.sv - directed self-checking bench for m_mem_access
module tb_m_mem_access;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk, reset, req_valid, addr_ovf, flush, bus_ack;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata, bus_rdata;
  logic        done, exc_valid, stall, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [4:0]  exc_code;
  logic [3:0]  bus_be;

  int n_pass, n_total;

  int          r_lat;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_we, r_exc_v, r_saw_req;
  logic [4:0]  r_exc_c;

  m_mem_access dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .mem_op(mem_op),
    .addr(addr), .addr_ovf(addr_ovf), .wdata(wdata), .flush(flush),
    .done(done), .rdata(rdata), .exc_valid(exc_valid), .exc_code(exc_code),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction, ack the bus after `delay` request cycles, record results
  task run_op(input logic [2:0] op, input logic [31:0] a, input logic ovf,
              input logic [31:0] wd, input logic [31:0] rd_word, input int delay);
    int w;
    w = 0;
    r_saw_req = 1'b0;
    req_valid = 1'b1; mem_op = op; addr = a; addr_ovf = ovf; wdata = wd;
    tick;
    r_lat = 1;
    while (!done && r_lat < 20) begin
      if (bus_req) begin
        if (!r_saw_req) begin
          r_addr = bus_addr; r_be = bus_be; r_wdata = bus_wdata; r_we = bus_we;
        end
        r_saw_req = 1'b1;
        if (w == delay) begin
          bus_ack = 1'b1; bus_rdata = rd_word;
        end
        w++;
      end
      tick;
      bus_ack = 1'b0;
      r_lat++;
    end
    r_rdata = rdata; r_exc_v = exc_valid; r_exc_c = exc_code;
    req_valid = 1'b0; addr_ovf = 1'b0;
    tick;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; req_valid = 1'b0; mem_op = LW; addr = 32'h0; addr_ovf = 1'b0;
    wdata = 32'h0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    tick; tick;
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_exc", {26'b0, exc_valid, exc_code}, 32'd0);
    reset = 1'b1;
    tick;

    run_op(LB, 32'h3, 1'b0, 32'h0, 32'h80FF_1234, 0);
    check("lb_lat", r_lat, 2);
    check("lb_rdata", r_rdata, 32'hFFFF_FF80);
    check("lb_bus", {r_be, 3'b0, r_we, r_addr[23:0]}, {4'hF, 3'b0, 1'b0, 24'h0});
    check("lb_exc", {31'b0, r_exc_v}, 32'd0);
    check("post_done", {31'b0, done}, 32'd0);

    run_op(LBU, 32'h3, 1'b0, 32'h0, 32'h80FF_1234, 0);
    check("lbu_rdata", r_rdata, 32'h0000_0080);
    run_op(LH, 32'h2, 1'b0, 32'h0, 32'h80FF_1234, 0);
    check("lh_rdata", r_rdata, 32'hFFFF_80FF);
    run_op(LHU, 32'h0, 1'b0, 32'h0, 32'h80FF_9234, 0);
    check("lhu_rdata", r_rdata, 32'h0000_9234);
    run_op(LW, 32'h2FFC, 1'b0, 32'h0, 32'hDEAD_BEEF, 1);
    check("lw_rdata", r_rdata, 32'hDEAD_BEEF);
    check("lw_lat_d1", r_lat, 3);

    run_op(SH, 32'h6, 1'b0, 32'h1234_ABCD, 32'h0, 0);
    check("sh_addr", r_addr, 32'h4);
    check("sh_be", {28'b0, r_be}, 32'hC);
    check("sh_wdata", r_wdata, 32'hABCD_ABCD);
    check("sh_we", {31'b0, r_we}, 32'd1);
    run_op(SB, 32'h1, 1'b0, 32'h0000_0055, 32'h0, 0);
    check("sb_be", {28'b0, r_be}, 32'h2);
    check("sb_wdata", r_wdata, 32'h5555_5555);

    run_op(LW, 32'h2, 1'b0, 32'h0, 32'h0, 0);
    check("misal_lat", r_lat, 1);
    check("misal_noreq", {31'b0, r_saw_req}, 32'd0);
    check("misal_exc", {26'b0, r_exc_v, r_exc_c}, {26'b0, 1'b1, 5'd4});
    check("exc_clear", {26'b0, exc_valid, exc_code}, 32'd0);

    run_op(SW, 32'h7F08, 1'b0, 32'h1, 32'h0, 0);
    check("sw_cnt_exc", {26'b0, r_exc_v, r_exc_c}, {26'b0, 1'b1, 5'd5});
    run_op(LH, 32'h7F00, 1'b0, 32'h0, 32'h0, 0);
    check("lh_timer_exc", {26'b0, r_exc_v, r_exc_c}, {26'b0, 1'b1, 5'd4});
    run_op(SW, 32'h7F04, 1'b0, 32'h7, 32'h0, 0);
    check("sw_timer_ok", {26'b0, r_exc_v, r_exc_c}, 32'd0);
    check("sw_timer_bus", {r_we, r_addr[30:0]}, {1'b1, 31'h7F04});
    run_op(LW, 32'h3000, 1'b0, 32'h0, 32'h0, 0);
    check("lw_oor_exc", {26'b0, r_exc_v, r_exc_c}, {26'b0, 1'b1, 5'd4});
    run_op(SW, 32'h7F0C, 1'b0, 32'h0, 32'h0, 0);
    check("sw_gap_exc", {26'b0, r_exc_v, r_exc_c}, {26'b0, 1'b1, 5'd5});
    run_op(LW, 32'h10, 1'b1, 32'h0, 32'h0, 0);
    check("ovf_exc", {26'b0, r_exc_v, r_exc_c}, {26'b0, 1'b1, 5'd4});
    run_op(LB, 32'h7F23, 1'b0, 32'h0, 32'h7F00_0000, 0);
    check("ig_lb", {r_exc_v, r_rdata[30:0]}, {1'b0, 31'h7F});

    // flush in the first WAIT cycle, ack arrives on the fourth request cycle
    begin
      logic done_seen;
      done_seen = 1'b0;
      req_valid = 1'b1; mem_op = LW; addr = 32'h8;
      tick;
      check("fl_stall", {31'b0, stall}, 32'd1);
      req_valid = 1'b0; flush = 1'b1;
      tick;
      flush = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (i == 0) check("fl_req_held", {31'b0, bus_req}, 32'd1);
        bus_ack = (i == 2);
        bus_rdata = 32'h1111_2222;
        done_seen = done_seen | done;
        tick;
        bus_ack = 1'b0;
        done_seen = done_seen | done;
      end
      check("fl_no_done", {31'b0, done_seen}, 32'd0);
      check("fl_req_low", {31'b0, bus_req}, 32'd0);
    end
    run_op(LW, 32'hC, 1'b0, 32'h0, 32'h0BAD_F00D, 0);
    check("post_fl_lat", r_lat, 2);
    check("post_fl_rdata", r_rdata, 32'h0BAD_F00D);

    req_valid = 1'b1; mem_op = SW; addr = 32'h10; wdata = 32'hCAFE_0001;
    tick;
    check("rw_req", {31'b0, bus_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rw_bus_req", {31'b0, bus_req}, 32'd0);
    check("rw_bus", {bus_we, bus_be, bus_addr[26:0]}, 32'd0);
    check("rw_wdata", bus_wdata, 32'd0);
    req_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    check("rw_idle", {30'b0, bus_req, done}, 32'd0);
    run_op(LBU, 32'h1, 1'b0, 32'h0, 32'h0000_A500, 0);
    check("rw_after_lat", r_lat, 2);
    check("rw_after_rdata", r_rdata, 32'h0000_00A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
